// File: rtl/wisc_pkg.sv
// Shared WISC definitions: opcode encodings, decode FSM states and
// per-instruction source/destination classification helpers.
package wisc_pkg;

    typedef enum logic [3:0] {
        OP_ADD    = 4'h0,
        OP_SUB    = 4'h1,
        OP_XOR    = 4'h2,
        OP_RED    = 4'h3,
        OP_SLL    = 4'h4,
        OP_SRA    = 4'h5,
        OP_ROR    = 4'h6,
        OP_PADDSB = 4'h7,
        OP_LW     = 4'h8,
        OP_SW     = 4'h9,
        OP_LLB    = 4'hA,
        OP_LHB    = 4'hB,
        OP_B      = 4'hC,
        OP_BR     = 4'hD,
        OP_PCS    = 4'hE,
        OP_HLT    = 4'hF
    } opcode_e;

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_LDSTALL = 2'd1,
        ST_HALT    = 2'd2
    } state_e;

    typedef struct packed {
        logic [3:0] rs;
        logic [3:0] rt;
        logic       use_rs;
        logic       use_rt;
    } src_dec_t;

    // Unused source slots come back as register 0 with their use flag clear.
    function automatic src_dec_t decode_src(input logic [15:0] instr);
        src_dec_t s;
        s = '0;
        case (opcode_e'(instr[15:12]))
            OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_PADDSB: begin
                s.rs = instr[7:4];  s.use_rs = 1'b1;
                s.rt = instr[3:0];  s.use_rt = 1'b1;
            end
            OP_SLL, OP_SRA, OP_ROR, OP_LW, OP_BR: begin
                s.rs = instr[7:4];  s.use_rs = 1'b1;
            end
            OP_SW: begin
                s.rs = instr[7:4];  s.use_rs = 1'b1;
                s.rt = instr[11:8]; s.use_rt = 1'b1;
            end
            OP_LLB, OP_LHB: begin
                s.rs = instr[11:8]; s.use_rs = 1'b1;
            end
            default: ;
        endcase
        return s;
    endfunction

    function automatic logic writes_reg(input opcode_e op);
        case (op)
            OP_ADD, OP_SUB, OP_XOR, OP_RED, OP_SLL, OP_SRA, OP_ROR, OP_PADDSB,
            OP_LW, OP_LLB, OP_LHB, OP_PCS: return 1'b1;
            default:                       return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/decode_stage_imm_gen.sv
// Immediate generator: per-opcode extraction and extension of the
// instruction's immediate field into a 16-bit operand.
module imm_gen
    import wisc_pkg::*;
(
    input  logic [15:0] instr,
    output logic [15:0] imm
);

    // Branch condition code bits never contribute to an immediate.
    logic unused_ccc;
    assign unused_ccc = ^instr[11:9];

    always_comb begin
        imm = '0;
        case (opcode_e'(instr[15:12]))
            OP_LW, OP_SW:          imm = {{11{instr[3]}}, instr[3:0], 1'b0};
            OP_SLL, OP_SRA, OP_ROR: imm = {12'h000, instr[3:0]};
            OP_LLB, OP_LHB:        imm = {8'h00, instr[7:0]};
            OP_B:                  imm = {{6{instr[8]}}, instr[8:0], 1'b0};
            default:               imm = '0;
        endcase
    end

endmodule

// File: rtl/decode_stage.sv
// WISC decode stage: source decode, load-use interlock, HLT handling and
// the ID/EX pipeline register. DECODE_WB_BYPASS_EN forwards the WB port.
module decode_stage
    import wisc_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        if_id_valid,
    input  logic [15:0] if_id_instr,
    input  logic [15:0] if_id_pc,
    input  logic        flush,
    output logic [3:0]  src_reg1,
    output logic [3:0]  src_reg2,
    input  logic [15:0] rf_data1,
    input  logic [15:0] rf_data2,
    input  logic        wb_write_reg,
    input  logic [3:0]  wb_dst_reg,
    input  logic [15:0] wb_dst_data,
    output logic        stall,
    output logic        id_ex_valid,
    output logic [3:0]  id_ex_opcode,
    output logic [3:0]  id_ex_rd,
    output logic [3:0]  id_ex_rs,
    output logic [3:0]  id_ex_rt,
    output logic [15:0] id_ex_a,
    output logic [15:0] id_ex_b,
    output logic [15:0] id_ex_imm,
    output logic [15:0] id_ex_pc,
    output logic        id_ex_write_reg,
    output logic        id_ex_mem_read,
    output logic        id_ex_mem_write,
    output logic        halted,
    output logic [15:0] stall_cycles
);

    state_e      state_q, state_d;
    logic        halted_q, halted_d;
    logic [15:0] stall_cycles_q, stall_cycles_d;
    logic        valid_q, valid_d;
    logic [3:0]  opcode_q, opcode_d, rd_q, rd_d, rs_q, rs_d, rt_q, rt_d;
    logic [15:0] a_q, a_d, b_q, b_d, imm_q, imm_d, pc_q, pc_d;
    logic        write_reg_q, write_reg_d, mem_read_q, mem_read_d;
    logic        mem_write_q, mem_write_d;

    opcode_e     opc;
    src_dec_t    src;
    logic [15:0] imm_w, op_a, op_b;
    logic        hazard, issue, stall_raw;

    imm_gen u_imm_gen (
        .instr (if_id_instr),
        .imm   (imm_w)
    );

    assign opc      = opcode_e'(if_id_instr[15:12]);
    assign src      = decode_src(if_id_instr);
    assign src_reg1 = src.rs;
    assign src_reg2 = src.rt;

`ifdef DECODE_WB_BYPASS_EN
    assign op_a = (wb_write_reg && wb_dst_reg != 4'd0 && wb_dst_reg == src.rs) ? wb_dst_data : rf_data1;
    assign op_b = (wb_write_reg && wb_dst_reg != 4'd0 && wb_dst_reg == src.rt) ? wb_dst_data : rf_data2;
`else
    logic unused_wb;
    assign unused_wb = ^{wb_write_reg, wb_dst_reg, wb_dst_data};
    assign op_a = rf_data1;
    assign op_b = rf_data2;
`endif

    assign hazard = valid_q && mem_read_q && (rd_q != 4'd0) &&
                    ((src.use_rs && src.rs == rd_q) || (src.use_rt && src.rt == rd_q));

    always_comb begin
        state_d        = state_q;
        halted_d       = halted_q;
        stall_cycles_d = stall_cycles_q;
        stall_raw      = 1'b0;
        issue          = 1'b0;
        case (state_q)
            ST_HALT: stall_raw = 1'b1;
            default: begin
                if (flush) begin
                    state_d = ST_RUN;
                end else if (state_q == ST_RUN && if_id_valid && hazard) begin
                    stall_raw = 1'b1;
                    state_d   = ST_LDSTALL;
                    if (stall_cycles_q != 16'hFFFF)
                        stall_cycles_d = stall_cycles_q + 16'd1;
                end else begin
                    state_d = ST_RUN;
                    issue   = if_id_valid;
                    if (if_id_valid && opc == OP_HLT) begin
                        state_d  = ST_HALT;
                        halted_d = 1'b1;
                    end
                end
            end
        endcase

        // Data fields load unconditionally; only the control bits mark a bubble.
        valid_d     = issue;
        write_reg_d = issue && writes_reg(opc) && (if_id_instr[11:8] != 4'd0);
        mem_read_d  = issue && (opc == OP_LW);
        mem_write_d = issue && (opc == OP_SW);
        opcode_d    = if_id_instr[15:12];
        rd_d        = if_id_instr[11:8];
        rs_d        = src.rs;
        rt_d        = src.rt;
        a_d         = op_a;
        b_d         = op_b;
        imm_d       = imm_w;
        pc_d        = if_id_pc;
    end

    assign stall = stall_raw && !rst;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_RUN;
            halted_q       <= 1'b0;
            stall_cycles_q <= '0;
            valid_q        <= 1'b0;
            write_reg_q    <= 1'b0;
            mem_read_q     <= 1'b0;
            mem_write_q    <= 1'b0;
            opcode_q       <= '0;
            rd_q           <= '0;
            rs_q           <= '0;
            rt_q           <= '0;
            a_q            <= '0;
            b_q            <= '0;
            imm_q          <= '0;
            pc_q           <= '0;
        end else begin
            state_q        <= state_d;
            halted_q       <= halted_d;
            stall_cycles_q <= stall_cycles_d;
            valid_q        <= valid_d;
            write_reg_q    <= write_reg_d;
            mem_read_q     <= mem_read_d;
            mem_write_q    <= mem_write_d;
            opcode_q       <= opcode_d;
            rd_q           <= rd_d;
            rs_q           <= rs_d;
            rt_q           <= rt_d;
            a_q            <= a_d;
            b_q            <= b_d;
            imm_q          <= imm_d;
            pc_q           <= pc_d;
        end
    end

    assign halted          = halted_q;
    assign stall_cycles    = stall_cycles_q;
    assign id_ex_valid     = valid_q;
    assign id_ex_opcode    = opcode_q;
    assign id_ex_rd        = rd_q;
    assign id_ex_rs        = rs_q;
    assign id_ex_rt        = rt_q;
    assign id_ex_a         = a_q;
    assign id_ex_b         = b_q;
    assign id_ex_imm       = imm_q;
    assign id_ex_pc        = pc_q;
    assign id_ex_write_reg = write_reg_q;
    assign id_ex_mem_read  = mem_read_q;
    assign id_ex_mem_write = mem_write_q;

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage: table of single-instruction decodes plus
// hand-written load-use, flush, reset and HLT sequences.
module tb_decode_stage;

    logic        clk, rst, if_id_valid, flush;
    logic [15:0] if_id_instr, if_id_pc, rf_data1, rf_data2, wb_dst_data;
    logic [3:0]  src_reg1, src_reg2, wb_dst_reg;
    logic        wb_write_reg, stall;
    logic        id_ex_valid, id_ex_write_reg, id_ex_mem_read, id_ex_mem_write, halted;
    logic [3:0]  id_ex_opcode, id_ex_rd, id_ex_rs, id_ex_rt;
    logic [15:0] id_ex_a, id_ex_b, id_ex_imm, id_ex_pc, stall_cycles;

    int errors = 0;
    int checks = 0;

    decode_stage dut (
        .clk(clk), .rst(rst), .if_id_valid(if_id_valid), .if_id_instr(if_id_instr),
        .if_id_pc(if_id_pc), .flush(flush), .src_reg1(src_reg1), .src_reg2(src_reg2),
        .rf_data1(rf_data1), .rf_data2(rf_data2), .wb_write_reg(wb_write_reg),
        .wb_dst_reg(wb_dst_reg), .wb_dst_data(wb_dst_data), .stall(stall),
        .id_ex_valid(id_ex_valid), .id_ex_opcode(id_ex_opcode), .id_ex_rd(id_ex_rd),
        .id_ex_rs(id_ex_rs), .id_ex_rt(id_ex_rt), .id_ex_a(id_ex_a), .id_ex_b(id_ex_b),
        .id_ex_imm(id_ex_imm), .id_ex_pc(id_ex_pc), .id_ex_write_reg(id_ex_write_reg),
        .id_ex_mem_read(id_ex_mem_read), .id_ex_mem_write(id_ex_mem_write),
        .halted(halted), .stall_cycles(stall_cycles)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] instr;
        logic [15:0] pc;
        logic [15:0] rf1;
        logic [15:0] rf2;
        logic [3:0]  rd;
        logic [3:0]  rs;
        logic [3:0]  rt;
        logic [15:0] imm;
        logic        wr;
        logic        mr;
        logic        mw;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [15:0] instr);
        if_id_valid = v;
        if_id_instr = instr;
    endtask

    task automatic chk_bubble(input string name);
        chk({name, "_valid"}, id_ex_valid, 0);
        chk({name, "_ctl"}, {id_ex_write_reg, id_ex_mem_read, id_ex_mem_write}, 0);
    endtask

    initial begin
        //         instr     pc        rf1       rf2       rd    rs    rt    imm       wr    mr    mw
        vecs[0]  = '{16'h0435, 16'h0102, 16'h1234, 16'h0F0F, 4'h4, 4'h3, 4'h5, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[1]  = '{16'h1012, 16'h0104, 16'hAAAA, 16'h5555, 4'h0, 4'h1, 4'h2, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[2]  = '{16'h4297, 16'h0106, 16'h0001, 16'h0002, 4'h2, 4'h9, 4'h0, 16'h0007, 1'b1, 1'b0, 1'b0};
        vecs[3]  = '{16'h8312, 16'h0108, 16'h2000, 16'h0000, 4'h3, 4'h1, 4'h0, 16'h0004, 1'b1, 1'b1, 1'b0};
        vecs[4]  = '{16'h926F, 16'h010A, 16'h3000, 16'h00C3, 4'h2, 4'h6, 4'h2, 16'hFFFE, 1'b0, 1'b0, 1'b1};
        vecs[5]  = '{16'hA5A5, 16'h010C, 16'hFF00, 16'h0000, 4'h5, 4'h5, 4'h0, 16'h00A5, 1'b1, 1'b0, 1'b0};
        vecs[6]  = '{16'hC4FF, 16'h010E, 16'h0000, 16'h0000, 4'h4, 4'h0, 4'h0, 16'h01FE, 1'b0, 1'b0, 1'b0};
        vecs[7]  = '{16'hD0A0, 16'h0110, 16'h4444, 16'h0000, 4'h0, 4'hA, 4'h0, 16'h0000, 1'b0, 1'b0, 1'b0};
        vecs[8]  = '{16'hE600, 16'h0112, 16'h0000, 16'h0000, 4'h6, 4'h0, 4'h0, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[9]  = '{16'h2FED, 16'h0114, 16'h7777, 16'h8888, 4'hF, 4'hE, 4'hD, 16'h0000, 1'b1, 1'b0, 1'b0};
        vecs[10] = '{16'hB180, 16'h0116, 16'h00FF, 16'h0000, 4'h1, 4'h1, 4'h0, 16'h0080, 1'b1, 1'b0, 1'b0};
        vecs[11] = '{16'h678F, 16'h0118, 16'h8001, 16'h0000, 4'h7, 4'h8, 4'h0, 16'h000F, 1'b1, 1'b0, 1'b0};

        rst = 1'b1; flush = 1'b0; if_id_valid = 1'b0; if_id_instr = '0; if_id_pc = '0;
        rf_data1 = '0; rf_data2 = '0; wb_write_reg = 1'b0; wb_dst_reg = '0; wb_dst_data = '0;
        tick(); tick();
        chk("rst_stall", stall, 0);
        rst = 1'b0;
        chk_bubble("rst");
        chk("rst_halted", halted, 0);
        chk("rst_cycles", stall_cycles, 0);

        // Table: each instruction issued once, followed by an idle cycle.
        for (int i = 0; i < 12; i++) begin
            drive(1'b1, vecs[i].instr);
            if_id_pc = vecs[i].pc; rf_data1 = vecs[i].rf1; rf_data2 = vecs[i].rf2;
            #1;
            chk($sformatf("v%0d_src1", i), src_reg1, vecs[i].rs);
            chk($sformatf("v%0d_src2", i), src_reg2, vecs[i].rt);
            chk($sformatf("v%0d_stall", i), stall, 0);
            tick();
            chk($sformatf("v%0d_valid", i), id_ex_valid, 1);
            chk($sformatf("v%0d_op", i), id_ex_opcode, vecs[i].instr[15:12]);
            chk($sformatf("v%0d_regs", i), {id_ex_rd, id_ex_rs, id_ex_rt},
                {vecs[i].rd, vecs[i].rs, vecs[i].rt});
            chk($sformatf("v%0d_ab", i), {id_ex_a, id_ex_b}, {vecs[i].rf1, vecs[i].rf2});
            chk($sformatf("v%0d_imm", i), id_ex_imm, vecs[i].imm);
            chk($sformatf("v%0d_pc", i), id_ex_pc, vecs[i].pc);
            chk($sformatf("v%0d_ctl", i), {id_ex_write_reg, id_ex_mem_read, id_ex_mem_write},
                {vecs[i].wr, vecs[i].mr, vecs[i].mw});
            drive(1'b0, 16'h0435);
            tick();
            chk_bubble($sformatf("v%0d_idle", i));
        end

        // Load-use: LW R3,R1,2 then ADD R4,R3,R5.
        drive(1'b1, 16'h8312); tick();
        drive(1'b1, 16'h0435); #1;
        chk("lu_stall", stall, 1);
        tick();
        chk_bubble("lu_bubble");
        chk("lu_cycles", stall_cycles, 1);
        chk("lu_release", stall, 0);
        tick();
        chk("lu_issue_valid", id_ex_valid, 1);
        chk("lu_issue_rs", id_ex_rs, 3);
        chk("lu_issue_rd", id_ex_rd, 4);
        drive(1'b0, 16'h0); #1;
        chk("lu_after_stall", stall, 0);
        tick();

        // Load to R0 never interlocks.
        drive(1'b1, 16'h8012); tick();
        drive(1'b1, 16'h0405); #1;
        chk("r0_stall", stall, 0);
        tick();
        chk("r0_valid", id_ex_valid, 1);
        chk("r0_cycles", stall_cycles, 1);

        // Flush coinciding with a load-use hazard.
        drive(1'b1, 16'h8312); tick();
        drive(1'b1, 16'h0435); flush = 1'b1; #1;
        chk("fl_stall", stall, 0);
        tick();
        flush = 1'b0;
        chk_bubble("fl_bubble");
        chk("fl_cycles", stall_cycles, 1);
        #1;
        chk("fl_nostall", stall, 0);
        tick();
        chk("fl_next_valid", id_ex_valid, 1);
        chk("fl_halted", halted, 0);

        // Reset during a load-use stall drops the held instruction.
        drive(1'b1, 16'h8312); tick();
        drive(1'b1, 16'h0435); #1;
        chk("rs_stall", stall, 1);
        rst = 1'b1; #1;
        chk("rs_stall_in_rst", stall, 0);
        tick();
        rst = 1'b0;
        chk_bubble("rs_bubble");
        chk("rs_cycles", stall_cycles, 0);
        tick();
        chk("rs_reissue", id_ex_valid, 1);

        // Writeback bypass into operand A, and WB to R0 never bypasses.
        drive(1'b1, 16'h0475); rf_data1 = 16'h1111; rf_data2 = 16'h2222;
        wb_write_reg = 1'b1; wb_dst_reg = 4'd7; wb_dst_data = 16'hBEEF;
        tick();
`ifdef DECODE_WB_BYPASS_EN
        chk("byp_a", id_ex_a, 16'hBEEF);
`else
        chk("byp_a", id_ex_a, 16'h1111);
`endif
        chk("byp_b", id_ex_b, 16'h2222);
        drive(1'b1, 16'h0405); rf_data1 = 16'h3333; wb_dst_reg = 4'd0;
        tick();
        chk("byp_r0_a", id_ex_a, 16'h3333);
        wb_write_reg = 1'b0;

        // HLT: halted and stall held, only bubbles, flush ignored, rst exits.
        drive(1'b1, 16'hF000); #1;
        chk("hlt_pre_stall", stall, 0);
        tick();
        chk("hlt_valid", id_ex_valid, 1);
        chk("hlt_op", id_ex_opcode, 4'hF);
        chk("hlt_halted", halted, 1);
        drive(1'b1, 16'h0435);
        for (int c = 0; c < 10; c++) begin
            flush = (c == 4);
            #1;
            chk($sformatf("hlt_stall_%0d", c), stall, 1);
            tick();
            chk($sformatf("hlt_halted_%0d", c), halted, 1);
            chk_bubble($sformatf("hlt_c%0d", c));
        end
        flush = 1'b0;
        chk("hlt_cycles", stall_cycles, 0);
        rst = 1'b1; #1;
        chk("hlt_rst_stall", stall, 0);
        tick();
        rst = 1'b0;
        chk("hlt_rst_halted", halted, 0);
        #1;
        chk("hlt_rst_run_stall", stall, 0);
        tick();
        chk("hlt_rst_issue", id_ex_valid, 1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
DECODE_STAGE -- requirements
Module: decode_stage

Interface
REQ-001 SHALL have no parameters; widths are fixed (16-bit datapath, 16 registers, 4-bit register IDs).
REQ-002 SHALL have these ports, in this order:
clk  in  1  single clock; all state updates on posedge
rst  in  1  synchronous, active-high reset
if_id_valid  in  1  IF/ID holds a live instruction
if_id_instr  in  16  opcode[15:12], field A[11:8], field B[7:4], field C[3:0]
if_id_pc  in  16  PC+2 of the instruction
flush  in  1  squash the instruction now in decode (taken branch in EX)
src_reg1, src_reg2  out  4 each  register-file read addresses (combinational)
rf_data1, rf_data2  in  16 each  register-file read data
wb_write_reg, wb_dst_reg[3:0], wb_dst_data[15:0]  in  -  writeback-port mirror
stall  out  1  hold PC and IF/ID
id_ex_valid, id_ex_opcode[3:0], id_ex_rd[3:0], id_ex_rs[3:0], id_ex_rt[3:0]  out  -  ID/EX register
id_ex_a, id_ex_b, id_ex_imm, id_ex_pc  out  16 each  ID/EX operands
id_ex_write_reg, id_ex_mem_read, id_ex_mem_write  out  1 each  ID/EX controls
halted  out  1  HLT has issued
stall_cycles  out  16  saturating load-use stall count

Function
REQ-003 Source decode SHALL be: ADD/SUB/XOR/RED/PADDSB use rs=B, rt=C; SLL/SRA/ROR use rs=B; LW uses rs=B; SW uses rs=B, rt=A; LLB/LHB use rs=A; BR uses rs=B; B/PCS/HLT use none. Unused src_reg outputs SHALL be 0.
REQ-004 Destination SHALL be A; id_ex_write_reg SHALL be 1 for ADD..PADDSB, LW, LLB, LHB and PCS, and 0 when A=0.
REQ-005 id_ex_imm SHALL be: LW/SW sext(C)<<1; SLL/SRA/ROR zext(C); LLB/LHB zext([7:0]); B sext([8:0])<<1; otherwise 0.
REQ-006 id_ex_mem_read SHALL be 1 only for LW; id_ex_mem_write SHALL be 1 only for SW.
REQ-007 Latency SHALL be one cycle from a valid IF/ID to ID/EX.
REQ-008 The FSM SHALL have three states: RUN, LDSTALL and HALT.
REQ-009 In RUN, a load-use hazard SHALL be id_ex_valid & id_ex_mem_read & id_ex_rd!=0 & id_ex_rd equal to a used source. On a hazard: assert stall combinationally, load a bubble (id_ex_valid=0) and go to LDSTALL.
REQ-010 LDSTALL SHALL deassert stall, issue the held instruction and return to RUN. The hazard SHALL NOT re-trigger because the bubble is in ID/EX.
REQ-011 flush SHALL take priority over stall: it loads a bubble, clears pending LDSTALL to RUN, and does not enter HALT.
REQ-012 Issuing a valid, unflushed HLT SHALL enter HALT. HALT holds stall=1 and halted=1 and loads only bubbles; only rst exits HALT, and flush is ignored there.
REQ-013 if_id_valid=0 SHALL load a bubble with no hazard check.
REQ-014 stall_cycles SHALL increment on every cycle with stall=1 in RUN and saturate at 16'hFFFF.
REQ-015 On a bubble, all ID/EX control bits (valid, write_reg, mem_read, mem_write) SHALL be 0; data fields are don't-care.

Reset
REQ-016 On rst, the block SHALL enter RUN and set all ID/EX outputs, halted and stall_cycles to 0.
REQ-017 rst asserted mid-stall or in HALT SHALL abandon the held instruction, and stall SHALL be 0 during reset.

Configuration
REQ-018 With DECODE_WB_BYPASS_EN defined: if wb_write_reg & wb_dst_reg!=0 & wb_dst_reg==src_regN, operand N SHALL take wb_dst_data (write-before-read in the same cycle).
REQ-019 Without DECODE_WB_BYPASS_EN, operands SHALL be rf_data1/2 unmodified.

Structure
REQ-020 Opcode constants and FSM state encodings SHALL live in the shared package wisc_pkg.
REQ-021 Immediate generation SHALL be the sub-module imm_gen (inputs: instr; output: imm[15:0]).

Verification
REQ-022 The bench SHALL cover these directed scenarios:
- LW R3,R1,2 then ADD R4,R3,R5 -> one stall cycle, one bubble, ADD issues with id_ex_rs=3; stall_cycles=1.
- LW R0,... then ADD R4,R0,R5 -> no stall.
- flush in the same cycle as a load-use hazard -> no stall, bubble issued, FSM in RUN.
- HLT issued -> halted=1 and stall=1 held for 10 cycles; rst returns halted=0.
- With DECODE_WB_BYPASS_EN: WB writes R7=16'hBEEF while ADD reads R7 -> id_ex_a=16'hBEEF. Without the macro -> rf_data1.
- SW R2,R6,-1 (offset 4'hF) -> id_ex_imm=16'hFFFE, id_ex_rt=2, id_ex_mem_write=1, id_ex_write_reg=0.
